// File: rtl/array_ctrl.sv
// ============================================================================
// array_ctrl
// ----------------------------------------------------------------------------
// Turns the memory-controller frame stream from axi_slave into array
// commands: row activate, column read/write, and precharge, each with
// programmable timing. Read data returns to axi_slave in issue order.
// One row stays open per frame burst (sof..eof). The row closes at eof, or
// when a frame targets another row or starts a new burst.
//
// Optional feature macro: REFRESH_EN
//   Defined   : periodic refresh (REF state, interval counter, array_ref pulse)
//   Undefined : no refresh logic, array_ref tied low
//
// Ports
//   clk              : clock
//   reset            : asynchronous, active-high reset
//   mc_frame_valid   : frame valid
//   mc_frame_ready   : frame accepted when valid && ready
//   mc_frame_data    : {sof, eof, wr, row, col, data}
//   array_act        : row activate pulse
//   array_pre        : precharge pulse
//   array_ref        : refresh pulse
//   array_row_addr   : open row, held while the row is open
//   array_col_addr   : column for the current read/write strobe
//   array_wr_en      : column write strobe
//   array_rd_en      : column read strobe
//   array_wdata      : write data
//   array_rdata      : array read data, valid RD_LATENCY cycles after rd_en
//   axi_array_rvalid : read data valid to axi_slave
//   axi_array_rdata  : read data to axi_slave
// ============================================================================
module array_ctrl #(
   parameter int ARRAY_ROW_ADDR   = 14,
   parameter int ARRAY_COL_ADDR   = 6,
   parameter int ARRAY_DATA_WIDTH = 64,
   parameter int FRAME_DATA_WIDTH = 3 + ARRAY_ROW_ADDR + ARRAY_COL_ADDR + ARRAY_DATA_WIDTH,
   parameter int T_RCD            = 3,
   parameter int T_RP             = 3,
   parameter int RD_LATENCY       = 2,
   parameter int REF_INTERVAL     = 1024,
   parameter int T_RFC            = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        mc_frame_valid,
   output logic                        mc_frame_ready,
   input  logic [FRAME_DATA_WIDTH-1:0] mc_frame_data,
   output logic                        array_act,
   output logic                        array_pre,
   output logic                        array_ref,
   output logic [ARRAY_ROW_ADDR-1:0]   array_row_addr,
   output logic [ARRAY_COL_ADDR-1:0]   array_col_addr,
   output logic                        array_wr_en,
   output logic                        array_rd_en,
   output logic [ARRAY_DATA_WIDTH-1:0] array_wdata,
   input  logic [ARRAY_DATA_WIDTH-1:0] array_rdata,
   output logic                        axi_array_rvalid,
   output logic [ARRAY_DATA_WIDTH-1:0] axi_array_rdata
);

   // Frame field positions, LSB first: data, col, row, wr, eof, sof.
   localparam int COL_LSB = ARRAY_DATA_WIDTH;
   localparam int ROW_LSB = COL_LSB + ARRAY_COL_ADDR;
   localparam int WR_BIT  = ROW_LSB + ARRAY_ROW_ADDR;
   localparam int EOF_BIT = WR_BIT + 1;
   localparam int SOF_BIT = EOF_BIT + 1;

   // One shared timing counter serves tRCD, tRP and tRFC, sized for the longest.
   localparam int CNT_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int CNT_MAX   = (CNT_MAX_A > T_RFC) ? CNT_MAX_A : T_RFC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   // Reject parameter sets that would break the timing counters or frame slicing.
   if (T_RCD < 1 || T_RP < 1 || RD_LATENCY < 1 || REF_INTERVAL < 1 || T_RFC < 1 ||
       FRAME_DATA_WIDTH != SOF_BIT + 1) begin : g_bad_param
      $error("array_ctrl: illegal parameter combination");
   end

`ifdef REFRESH_EN
   typedef enum logic [2:0] {
      IDLE, ACT, RCD, ACCESS, LAST, PRE, RP, REF
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, ACT, RCD, ACCESS, LAST, PRE, RP
   } state_t;
`endif

   state_t                       state;
   logic [CNT_W-1:0]             cnt;
   logic [ARRAY_ROW_ADDR-1:0]    open_row;
   logic                         first_frame;
   logic                         ref_pending;
   logic [RD_LATENCY-1:0]        rd_pipe;

   logic                         f_sof;
   logic                         f_eof;
   logic                         f_wr;
   logic [ARRAY_ROW_ADDR-1:0]    f_row;
   logic [ARRAY_COL_ADDR-1:0]    f_col;
   logic [ARRAY_DATA_WIDTH-1:0]  f_data;
   logic                         frame_fits;

   assign f_sof  = mc_frame_data[SOF_BIT];
   assign f_eof  = mc_frame_data[EOF_BIT];
   assign f_wr   = mc_frame_data[WR_BIT];
   assign f_row  = mc_frame_data[ROW_LSB +: ARRAY_ROW_ADDR];
   assign f_col  = mc_frame_data[COL_LSB +: ARRAY_COL_ADDR];
   assign f_data = mc_frame_data[ARRAY_DATA_WIDTH-1:0];

   // A frame belongs to the open burst when it targets the open row and does
   // not start a new burst (sof is only tolerated on the first frame after ACT).
   assign frame_fits     = (f_row == open_row) && (!f_sof || first_frame);
   assign mc_frame_ready = (state == ACCESS) && mc_frame_valid && frame_fits;

   // Main sequencer. Command pulses are registered, so each pulse appears the
   // cycle after the state that requests it. A frame that does not fit the
   // open burst closes the row and stays pending on the input; IDLE then
   // reopens its row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         open_row       <= '0;
         first_frame    <= 1'b0;
         array_act      <= 1'b0;
         array_pre      <= 1'b0;
         array_row_addr <= '0;
`ifdef REFRESH_EN
         array_ref      <= 1'b0;
`endif
      end else begin
         array_act <= 1'b0;
         array_pre <= 1'b0;
`ifdef REFRESH_EN
         array_ref <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (ref_pending) begin
`ifdef REFRESH_EN
                  array_ref <= 1'b1;
                  cnt       <= CNT_W'(T_RFC - 1);
                  state     <= REF;
`endif
               end else if (mc_frame_valid) begin
                  open_row <= f_row;
                  state    <= ACT;
               end
            end
            ACT: begin
               array_act      <= 1'b1;
               array_row_addr <= open_row;
               first_frame    <= 1'b1;
               cnt            <= CNT_W'(T_RCD - 1);
               state          <= RCD;
            end
            RCD: begin
               if (cnt == '0) begin
                  state <= ACCESS;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ACCESS: begin
               if (mc_frame_ready) begin
                  first_frame <= 1'b0;
                  if (f_eof) begin
                     state <= LAST;
                  end
               end else if (mc_frame_valid) begin
                  state <= LAST;
               end
            end
            LAST: begin
               state <= PRE;
            end
            PRE: begin
               array_pre <= 1'b1;
               cnt       <= CNT_W'(T_RP - 1);
               state     <= RP;
            end
            RP: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
`ifdef REFRESH_EN
            REF: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
`endif
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Column command register: every accepted frame becomes exactly one read
   // or write strobe on the following cycle, so both strobes can never be
   // high together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         array_wr_en    <= 1'b0;
         array_rd_en    <= 1'b0;
         array_col_addr <= '0;
         array_wdata    <= '0;
      end else begin
         array_wr_en <= mc_frame_ready && f_wr;
         array_rd_en <= mc_frame_ready && !f_wr;
         if (mc_frame_ready) begin
            array_col_addr <= f_col;
            if (f_wr) begin
               array_wdata <= f_data;
            end
         end
      end
   end

   // Read return: a shift register follows each read strobe for RD_LATENCY
   // cycles; at its tap the array data is valid and gets captured. This path
   // runs independently of the sequencer, so in-flight reads survive the
   // precharge and idle states.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pipe          <= '0;
         axi_array_rvalid <= 1'b0;
         axi_array_rdata  <= '0;
      end else begin
         rd_pipe[0] <= array_rd_en;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
         axi_array_rvalid <= rd_pipe[RD_LATENCY-1];
         if (rd_pipe[RD_LATENCY-1]) begin
            axi_array_rdata <= array_rdata;
         end
      end
   end

`ifdef REFRESH_EN
   localparam int REF_W = $clog2(REF_INTERVAL + 1);

   logic [REF_W-1:0] ref_cnt;

   // Refresh interval timer. Expiry raises one pending request; a request
   // that is already pending absorbs further expiries. The request clears
   // when the REF state finishes its busy period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_cnt     <= '0;
         ref_pending <= 1'b0;
      end else begin
         if (ref_cnt == '0) begin
            ref_cnt     <= REF_W'(REF_INTERVAL - 1);
            ref_pending <= 1'b1;
         end else begin
            ref_cnt <= ref_cnt - REF_W'(1);
         end
         if (state == REF && cnt == '0) begin
            ref_pending <= 1'b0;
         end
      end
   end
`else
   assign ref_pending = 1'b0;
   assign array_ref   = 1'b0;
`endif

endmodule

// File: tb/tb_array_ctrl.sv
// ============================================================================
// tb_array_ctrl
// ----------------------------------------------------------------------------
// Directed bench for array_ctrl. Column commands and read returns are
// scoreboarded: expectations are queued when a frame is handed over and
// compared when the DUT issues the command or returns the data. A small
// array model returns data derived from row/column after RD_LATENCY cycles.
// ============================================================================
module tb_array_ctrl;

   localparam int RW  = 14;
   localparam int CW  = 6;
   localparam int DW  = 64;
   localparam int FW  = 3 + RW + CW + DW;
   localparam int RDL = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          mc_frame_valid;
   logic          mc_frame_ready;
   logic [FW-1:0] mc_frame_data;
   logic          array_act;
   logic          array_pre;
   logic          array_ref;
   logic [RW-1:0] array_row_addr;
   logic [CW-1:0] array_col_addr;
   logic          array_wr_en;
   logic          array_rd_en;
   logic [DW-1:0] array_wdata;
   logic [DW-1:0] array_rdata;
   logic          axi_array_rvalid;
   logic [DW-1:0] axi_array_rdata;

   typedef struct {
      logic          wr;
      logic [CW-1:0] col;
      logic [RW-1:0] row;
      logic [DW-1:0] data;
      int            cyc;
   } cmd_t;

   cmd_t          cmd_q[$];
   logic [DW-1:0] rd_q[$];
   int            rd_time_q[$];

   int n_asserts = 0;
   int n_fails   = 0;
   int cyc       = 0;
   int act_count = 0;
   int pre_count = 0;
   int rv_count  = 0;
   int last_act_cyc = 0;
   int last_pre_cyc = 0;

   logic [DW-1:0] mem_pipe [RDL];

   array_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .mc_frame_valid   (mc_frame_valid),
      .mc_frame_ready   (mc_frame_ready),
      .mc_frame_data    (mc_frame_data),
      .array_act        (array_act),
      .array_pre        (array_pre),
      .array_ref        (array_ref),
      .array_row_addr   (array_row_addr),
      .array_col_addr   (array_col_addr),
      .array_wr_en      (array_wr_en),
      .array_rd_en      (array_rd_en),
      .array_wdata      (array_wdata),
      .array_rdata      (array_rdata),
      .axi_array_rvalid (axi_array_rvalid),
      .axi_array_rdata  (axi_array_rdata)
   );

   // Free-running clock and cycle index.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Content the array model returns for a given row/column.
   function automatic logic [DW-1:0] rd_model(input logic [RW-1:0] row, input logic [CW-1:0] col);
      return {32'h5EED0000 | 32'(row), 26'h0, col};
   endfunction

   // Array model: read data appears RDL cycles after the read strobe.
   always @(posedge clk) begin
      mem_pipe[0] <= array_rd_en ? rd_model(array_row_addr, array_col_addr) : '0;
      for (int i = 1; i < RDL; i++) mem_pipe[i] <= mem_pipe[i-1];
   end

   assign array_rdata = mem_pipe[RDL-1];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_asserts++;
      assert (observed === expected) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one frame and holds it until accepted; queues the expected column
   // command (next cycle) and, for reads, the expected return data.
   task automatic applyStimulus(input logic sof, input logic eof, input logic wr,
                                input logic [RW-1:0] row, input logic [CW-1:0] col,
                                input logic [DW-1:0] data, output int ready_cyc);
      cmd_t e;
      int   waited = 0;
      bit   done   = 0;
      mc_frame_data  = {sof, eof, wr, row, col, data};
      mc_frame_valid = 1'b1;
      ready_cyc      = -1;
      while (!done && waited < 100) begin
         @(negedge clk);
         if (mc_frame_ready) done = 1;
         else waited++;
      end
      if (!done) begin
         checkOutput("handshake_timeout", 64'd0, 64'd1);
         mc_frame_valid = 1'b0;
      end else begin
         ready_cyc = cyc;
         e.wr = wr; e.col = col; e.row = row; e.data = data; e.cyc = cyc + 1;
         cmd_q.push_back(e);
         if (!wr) rd_q.push_back(rd_model(row, col));
         @(posedge clk); #1;
         mc_frame_valid = 1'b0;
      end
   endtask

   task automatic idleCycles(input int n);
      mc_frame_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ctrl"}, 64'({array_act, array_pre, array_ref, array_wr_en,
                                       array_rd_en, axi_array_rvalid, mc_frame_ready}), 64'd0);
      checkOutput({tag, "_row_addr"}, 64'(array_row_addr), 64'd0);
      checkOutput({tag, "_col_addr"}, 64'(array_col_addr), 64'd0);
      checkOutput({tag, "_wdata"}, array_wdata, 64'd0);
      checkOutput({tag, "_rdata"}, axi_array_rdata, 64'd0);
   endtask

   // Output monitor: pulse exclusivity, column commands against the command
   // scoreboard, read returns against the data scoreboard and latency.
   always @(negedge clk) begin : monitor
      cmd_t e;
      if (array_act || array_pre || array_ref)
         checkOutput("act_pre_ref_exclusive", 64'(array_act) + 64'(array_pre) + 64'(array_ref), 64'd1);
      if (array_act) begin act_count++; last_act_cyc = cyc; end
      if (array_pre) begin pre_count++; last_pre_cyc = cyc; end
      if (array_wr_en || array_rd_en) begin
         checkOutput("wr_rd_exclusive", 64'(array_wr_en && array_rd_en), 64'd0);
         if (cmd_q.size() == 0) begin
            checkOutput("cmd_expected", 64'd0, 64'd1);
         end else begin
            e = cmd_q.pop_front();
            checkOutput("cmd_cycle", 64'(cyc), 64'(e.cyc));
            checkOutput("cmd_wr", 64'(array_wr_en), 64'(e.wr));
            checkOutput("cmd_col", 64'(array_col_addr), 64'(e.col));
            checkOutput("cmd_row", 64'(array_row_addr), 64'(e.row));
            if (e.wr) checkOutput("cmd_wdata", array_wdata, e.data);
         end
         if (array_rd_en) rd_time_q.push_back(cyc);
      end
      if (axi_array_rvalid) begin
         rv_count++;
         if (rd_q.size() == 0) begin
            checkOutput("rvalid_expected", 64'd0, 64'd1);
         end else begin
            checkOutput("rdata", axi_array_rdata, rd_q.pop_front());
            if (rd_time_q.size() != 0)
               checkOutput("rd_latency", 64'(cyc - rd_time_q.pop_front()), 64'(RDL + 1));
         end
      end
   end

   initial begin
      int rc;
      int rcs [4];
      int t1_act, acts0, pres0, rv0, waited;
      logic          bp_wr  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [CW-1:0] bp_col [4] = '{6'd10, 6'd11, 6'd12, 6'd13};
      logic [DW-1:0] bp_dat [4] = '{64'h1111_2222_3333_4444, 64'h0,
                                    64'hDEAD_BEEF_0BAD_F00D, 64'h0};
      int            bp_gap [4] = '{1, 1, 2, 0};

      reset          = 1'b1;
      mc_frame_valid = 1'b0;
      mc_frame_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset_state");
      reset = 1'b0;

      // Single write burst with exact command timing.
      $display("[TB] single write burst");
      applyStimulus(1'b1, 1'b1, 1'b1, 14'h0005, 6'h03, 64'hA5A5_A5A5_A5A5_A5A5, rc);
      t1_act = last_act_cyc;
      checkOutput("t1_ready_after_act", 64'(rc - t1_act), 64'd3);
      acts0 = act_count;

      // 4-beat read burst, launched while the first burst is still closing.
      $display("[TB] four-beat read burst");
      for (int c = 0; c < 4; c++) begin
         applyStimulus(c == 0, c == 3, 1'b0, 14'h0012, CW'(c), 64'h0, rcs[c]);
         if (c == 0) begin
            checkOutput("t1_pre_after_act", 64'(last_pre_cyc - t1_act), 64'd6);
            checkOutput("t2_act_after_t1_act", 64'(last_act_cyc - t1_act), 64'd11);
            checkOutput("t2_ready_after_act", 64'(rcs[0] - last_act_cyc), 64'd3);
            pres0 = pre_count;
            rv0   = rv_count;
         end
      end
      checkOutput("t2_back_to_back", 64'(rcs[3] - rcs[0]), 64'd3);
      idleCycles(8);
      checkOutput("t2_act_count", 64'(act_count - acts0), 64'd1);
      checkOutput("t2_pre_count", 64'(pre_count - pres0), 64'd1);
      checkOutput("t2_rvalid_count", 64'(rv_count - rv0), 64'd4);

      // Row change mid-stream: row 7 closes, row 8 waits for its own activate.
      $display("[TB] row change");
      acts0 = act_count;
      pres0 = pre_count;
      applyStimulus(1'b1, 1'b0, 1'b1, 14'h0007, 6'd62, 64'h0707_0707_0707_0707, rc);
      applyStimulus(1'b1, 1'b0, 1'b1, 14'h0008, 6'd0, 64'h0808_0808_0808_0808, rc);
      checkOutput("row8_ready_after_act", 64'(rc - last_act_cyc), 64'd3);
      checkOutput("row_change_acts", 64'(act_count - acts0), 64'd2);
      checkOutput("row_change_pres", 64'(pre_count - pres0), 64'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h0008, 6'd1, 64'h0, rc);
      idleCycles(8);
      checkOutput("row_change_pres_end", 64'(pre_count - pres0), 64'd2);

      // Backpressure: valid drops between frames inside one burst.
      $display("[TB] backpressure");
      rv0 = rv_count;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i == 0, i == 3, bp_wr[i], 14'h0020, bp_col[i], bp_dat[i], rc);
         if (bp_gap[i] > 0) idleCycles(bp_gap[i]);
      end
      idleCycles(8);
      checkOutput("bp_rvalid_count", 64'(rv_count - rv0), 64'd2);
      checkOutput("bp_cmd_q_drained", 64'(cmd_q.size()), 64'd0);

      // A new sof inside an open burst closes and reopens the same row.
      $display("[TB] new sof in open burst");
      acts0 = act_count;
      pres0 = pre_count;
      applyStimulus(1'b1, 1'b0, 1'b1, 14'h0030, 6'd5, 64'h3030_0000_0000_0005, rc);
      applyStimulus(1'b1, 1'b1, 1'b1, 14'h0030, 6'd6, 64'h3030_0000_0000_0006, rc);
      idleCycles(8);
      checkOutput("sof_reopen_acts", 64'(act_count - acts0), 64'd2);
      checkOutput("sof_reopen_pres", 64'(pre_count - pres0), 64'd2);

      // Reset during RCD: outputs clear at once, no precharge follows.
      $display("[TB] reset during RCD");
      pres0 = pre_count;
      acts0 = act_count;
      mc_frame_data  = {1'b1, 1'b1, 1'b1, 14'h0033, 6'd7, 64'h3333_3333_3333_3333};
      mc_frame_valid = 1'b1;
      waited = 0;
      while (waited < 20) begin
         @(negedge clk);
         if (array_act) break;
         waited++;
      end
      checkOutput("rcd_act_seen", 64'(waited < 20), 64'd1);
      @(posedge clk); #1;
      reset          = 1'b1;
      mc_frame_valid = 1'b0;
      #1;
      checkAllZero("reset_in_rcd");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idleCycles(10);
      checkOutput("rcd_reset_no_pre", 64'(pre_count - pres0), 64'd0);
      checkOutput("rcd_reset_one_act", 64'(act_count - acts0), 64'd1);

      // Reset while a read is in flight: the return is abandoned.
      $display("[TB] reset during read return");
      applyStimulus(1'b1, 1'b1, 1'b0, 14'h0044, 6'd9, 64'h0, rc);
      @(posedge clk); #1;
      reset = 1'b1;
      rd_q.delete();
      rd_time_q.delete();
      rv0 = rv_count;
      #1;
      checkAllZero("reset_in_read");
      @(posedge clk); #1;
      reset = 1'b0;
      idleCycles(10);
      checkOutput("no_rvalid_after_reset", 64'(rv_count - rv0), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
